// File: rtl/j1_boot_ctrl_pkg.sv
// j1_pkg: shared J1 boot types and code-RAM geometry.
// Used by the boot controller, code RAM and CPU fetch path.
package j1_pkg;

  localparam int J1_CODE_AW = 13;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DAT_LO,
    DAT_HI,
    CHECK,
    RUN,
    ERROR
  } boot_st_t;

endpackage

// File: rtl/j1_boot_ctrl_if.sv
// j1_boot_ctrl_if: RX byte handshake plus code-RAM write port.
// master = boot controller, slave = byte source / code RAM side.
interface j1_boot_ctrl_if
  import j1_pkg::*;
#(
  parameter int CODE_AW = J1_CODE_AW
);

  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               rx_ready;
  logic               code_we;
  logic [CODE_AW-1:0] code_waddr;
  logic [15:0]        code_wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, code_we,
    output code_waddr, code_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, code_we,
    input  code_waddr, code_wdata
  );

endinterface

// File: rtl/j1_boot_ctrl_timeout.sv
// j1_boot_timeout: idle counter, expired on the TIMEOUT_CYC-th
// consecutive enabled clock without a clear.
module j1_boot_timeout #(
  parameter int TIMEOUT_CYC = 1000000,
  parameter int TO_W        = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TO_W-1:0] cnt;

  assign expired = enable & ~clear &
    (cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (enable && !expired)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/j1_boot_ctrl.sv
// j1_boot_ctrl: J1 boot loader; streams an image into code RAM.
// Define J1_BOOT_CHECKSUM_EN to require a trailing sum byte.
module j1_boot_ctrl
  import j1_pkg::*;
#(
  parameter int CODE_AW     = J1_CODE_AW,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int TO_W        = 20
) (
  input  logic            clk,
  input  logic            reset,
  j1_boot_ctrl_if.master  bus,
  input  logic            boot_req,
  output logic            cpu_resetq,
  output logic            busy,
  output logic            err
);

`ifdef J1_BOOT_CHECKSUM_EN
  localparam boot_st_t FIN_ST = CHECK;
`else
  localparam boot_st_t FIN_ST = RUN;
`endif

  boot_st_t           state, nxt;
  logic [7:0]         len_lo, len_lo_n;
  logic [7:0]         lo, lo_n;
  logic [15:0]        n, n_n;
  logic [15:0]        widx, widx_n;
  logic               we, we_n;
  logic [CODE_AW-1:0] waddr, waddr_n;
  logic [15:0]        wdata, wdata_n;
  logic               acc, to_clr, to_en, expired;
  logic [15:0]        hdr;
`ifdef J1_BOOT_CHECKSUM_EN
  logic [7:0]         sum, sum_n;
`endif

  assign busy       = (state != RUN) && (state != ERROR);
  assign err        = (state == ERROR);
  assign cpu_resetq = (state == RUN);

  assign bus.rx_ready   = busy;
  assign bus.code_we    = we;
  assign bus.code_waddr = waddr;
  assign bus.code_wdata = wdata;

  assign acc    = bus.rx_valid & busy;
  assign hdr    = {bus.rx_data, len_lo};
  assign to_en  = busy && (state != LEN_LO);
  assign to_clr = acc | ~to_en;

  j1_boot_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_to (
    .clk     (clk),
    .reset   (reset),
    .clear   (to_clr),
    .enable  (to_en),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= LEN_LO;
      len_lo <= '0;
      lo     <= '0;
      n      <= '0;
      widx   <= '0;
      we     <= 1'b0;
      waddr  <= '0;
      wdata  <= '0;
`ifdef J1_BOOT_CHECKSUM_EN
      sum    <= '0;
`endif
    end else begin
      state  <= nxt;
      len_lo <= len_lo_n;
      lo     <= lo_n;
      n      <= n_n;
      widx   <= widx_n;
      we     <= we_n;
      waddr  <= waddr_n;
      wdata  <= wdata_n;
`ifdef J1_BOOT_CHECKSUM_EN
      sum    <= sum_n;
`endif
    end
  end

  always_comb begin
    nxt      = state;
    len_lo_n = len_lo;
    lo_n     = lo;
    n_n      = n;
    widx_n   = widx;
    we_n     = 1'b0;
    waddr_n  = waddr;
    wdata_n  = wdata;
`ifdef J1_BOOT_CHECKSUM_EN
    sum_n    = sum;
    if (acc)
      sum_n = (state == LEN_LO) ? bus.rx_data
                                : sum + bus.rx_data;
`endif
    unique case (state)
      LEN_LO: if (acc) begin
        len_lo_n = bus.rx_data;
        nxt      = LEN_HI;
      end
      LEN_HI: if (acc) begin
        n_n = hdr;
        if (32'(hdr) > (32'd1 << CODE_AW))
          nxt = ERROR;
        else if (hdr == 16'd0)
          nxt = FIN_ST;
        else
          nxt = DAT_LO;
      end else if (expired) nxt = ERROR;
      DAT_LO: if (acc) begin
        lo_n = bus.rx_data;
        nxt  = DAT_HI;
      end else if (expired) nxt = ERROR;
      DAT_HI: if (acc) begin
        we_n    = 1'b1;
        waddr_n = widx[CODE_AW-1:0];
        wdata_n = {bus.rx_data, lo};
        widx_n  = widx + 16'd1;
        nxt     = (widx == n - 16'd1) ? FIN_ST
                                      : DAT_LO;
      end else if (expired) nxt = ERROR;
`ifdef J1_BOOT_CHECKSUM_EN
      CHECK: if (acc) begin
        nxt = (bus.rx_data == sum) ? RUN : ERROR;
      end else if (expired) nxt = ERROR;
`endif
      RUN, ERROR: if (boot_req) begin
        nxt    = LEN_LO;
        widx_n = '0;
      end
      default: nxt = LEN_LO;
    endcase
  end

endmodule

// File: tb/tb_j1_boot_ctrl.sv
// tb_j1_boot_ctrl: directed image loads, writes checked by a
// scoreboard monitor; status checks inline.
module tb_j1_boot_ctrl;
  import j1_pkg::*;

  localparam int AW = 13;

  logic clk = 1'b0;
  logic reset;
  logic boot_req;
  logic cpu_resetq, busy, err;

  int vectors = 0;
  int miscompares = 0;

  logic [AW+15:0] exp_q[$];

  j1_boot_ctrl_if #(.CODE_AW(AW)) bus ();

  j1_boot_ctrl #(
    .CODE_AW     (AW),
    .TIMEOUT_CYC (16),
    .TO_W        (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.master),
    .boot_req   (boot_req),
    .cpu_resetq (cpu_resetq),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // monitor: every write strobe must match the queue head
  always @(negedge clk) begin
    if (bus.code_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got %0h/%0h expected none",
                 bus.code_waddr, bus.code_wdata);
      end else begin
        logic [AW+15:0] e;
        e = exp_q.pop_front();
        chk("write", {bus.code_waddr, bus.code_wdata}, 32'(e));
      end
    end
  end

  task automatic send(logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1 bus.rx_valid = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic rearm();
    boot_req = 1'b1;
    @(posedge clk);
    #1 boot_req = 1'b0;
  endtask

  task automatic expect_wr(logic [AW-1:0] a, logic [15:0] d);
    exp_q.push_back({a, d});
  endtask

  // status: {cpu_resetq, busy, err, rx_ready}
  task automatic st(string nm, logic [3:0] exp);
    chk(nm, {cpu_resetq, busy, err, bus.rx_ready}, 32'(exp));
  endtask

  initial begin
    reset        = 1'b1;
    boot_req     = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    @(posedge clk);
    #1;
    chk("rst_we", bus.code_we, 0);
    chk("rst_addr", bus.code_waddr, 0);
    chk("rst_data", bus.code_wdata, 0);
    st("rst_status", 4'b0101);
    reset = 1'b0;

    // two-word image
    expect_wr(0, 16'h1234);
    expect_wr(1, 16'hABCD);
    send(8'h02); send(8'h00);
    send(8'h34); send(8'h12);
    send(8'hCD);
    st("two_mid", 4'b0101);
    send(8'hAB);
`ifdef J1_BOOT_CHECKSUM_EN
    st("two_check", 4'b0101);
    send(8'hC0);
`endif
    st("two_run", 4'b1000);

    // re-arm with a byte offered in the same cycle
    bus.rx_data  = 8'h55;
    bus.rx_valid = 1'b1;
    rearm();
    bus.rx_valid = 1'b0;
    st("rearm", 4'b0101);
    expect_wr(0, 16'hBEEF);
    send(8'h01); send(8'h00);
    send(8'hEF); send(8'hBE);
`ifdef J1_BOOT_CHECKSUM_EN
    send(8'hAE);
`endif
    st("rearm_run", 4'b1000);

    // bytes in RUN are left for the CPU
    send(8'h77);
    st("run_ignore", 4'b1000);

    // 01 00 01 80: sum 0x82
    do_reset();
    expect_wr(0, 16'h8001);
    send(8'h01); send(8'h00);
    send(8'h01); send(8'h80);
`ifdef J1_BOOT_CHECKSUM_EN
    send(8'h82);
    st("csum_ok", 4'b1000);
    do_reset();
    expect_wr(0, 16'h8001);
    send(8'h01); send(8'h00);
    send(8'h01); send(8'h80);
    send(8'h83);
    st("csum_bad", 4'b0010);
    send(8'h82);
    st("csum_bad_hold", 4'b0010);
`else
    st("one_run", 4'b1000);
`endif

    // oversize header N=0x2001
    do_reset();
    send(8'h01); send(8'h20);
    st("oversize", 4'b0010);
    send(8'h00); send(8'h00);
    st("err_hold", 4'b0010);
    rearm();
    st("err_rearm", 4'b0101);

    // timeout: 15 idle ok, 16th expires
    do_reset();
    send(8'h01); send(8'h00);
    idle(15);
    st("to_15", 4'b0101);
    idle(1);
    st("to_16", 4'b0010);

    // byte on the expiry cycle wins
    do_reset();
    expect_wr(0, 16'h1234);
    send(8'h01); send(8'h00);
    idle(15);
    send(8'h34);
    st("to_accept", 4'b0101);
    send(8'h12);
`ifdef J1_BOOT_CHECKSUM_EN
    send(8'h47);
`endif
    st("to_accept_run", 4'b1000);

    // reset mid-load in DAT_HI, then empty image
    do_reset();
    send(8'h02); send(8'h00); send(8'h34);
    do_reset();
    chk("mid_we", bus.code_we, 0);
    chk("mid_addr", bus.code_waddr, 0);
    st("mid_status", 4'b0101);
    send(8'h00); send(8'h00);
`ifdef J1_BOOT_CHECKSUM_EN
    send(8'h00);
`endif
    st("empty_run", 4'b1000);

    idle(3);
    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/j1_boot_ctrl.md
Name: j1_boot_ctrl

Overview:
- Boot sequencer for the J1 core. After reset it holds the CPU in reset and loads code RAM from a byte stream, normally a UART receiver.
- On a good image it releases the CPU so execution starts at address 0.
- It sits between the RX byte source, the code-RAM write port and the CPU reset input.
- It can be re-armed at runtime to reload a new image.

Parameters:
- CODE_AW, 13, code-RAM word-address width; the image limit is 2**CODE_AW words.
- TIMEOUT_CYC, 1000000, maximum idle clocks between bytes once a load has started; must be at least 2.
- TO_W, 20, timeout counter width; must satisfy 2**TO_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid this cycle
- rx_ready  out  1  controller accepts a byte; transfer occurs when rx_valid & rx_ready
- boot_req  in  1  single-cycle pulse; re-arm loader from RUN or ERROR
- code_we  out  1  code-RAM write strobe, one cycle per word
- code_waddr  out  CODE_AW  code-RAM word address
- code_wdata  out  16  code-RAM write data
- cpu_resetq  out  1  active-low reset to the J1 core
- busy  out  1  a load is in progress (any state except RUN and ERROR)
- err  out  1  load failed

Behaviour:
- Reset values: state=LEN_LO, cpu_resetq=0, rx_ready=1, code_we=0, code_waddr=0, code_wdata=0, busy=1, err=0.
- Image format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N words of 16 bits, each sent low byte first.
- States and transitions:
  - LEN_LO: on accept, latch the length low byte -> LEN_HI.
  - LEN_HI: on accept, form N.
    - N > 2**CODE_AW -> ERROR.
    - N == 0 -> CHECK if the checksum feature is compiled in, else RUN.
    - otherwise -> DAT_LO.
  - DAT_LO: on accept, latch the low byte -> DAT_HI.
  - DAT_HI: on accept, write the word and increment the word index.
    - Last word -> CHECK (feature on) or RUN (feature off).
    - Otherwise -> DAT_LO.
  - RUN: rx_ready=0, cpu_resetq=1, busy=0. Incoming bytes are not consumed; they belong to the CPU I/O path.
  - ERROR: rx_ready=0, cpu_resetq=0, err=1, busy=0.
- Word writes:
  - code_we is registered and asserted for exactly one cycle, the cycle after the DAT_HI accept.
  - code_waddr = word index (0..N-1); code_wdata = {hi, lo}.
- Release timing: cpu_resetq rises on the clock edge that enters RUN, which is no earlier than the edge registering the final code_we. The last RAM write therefore completes before the CPU fetches.
- rx_ready is 1 in LEN_LO, LEN_HI, DAT_LO, DAT_HI and CHECK; 0 in RUN and ERROR.
- Timeout:
  - The counter clears on every accepted byte and is held clear in LEN_LO, RUN and ERROR.
  - In any other loading state, TIMEOUT_CYC consecutive clocks without an accept -> ERROR.
  - LEN_LO waits indefinitely.
- Re-arm:
  - boot_req in RUN or ERROR -> LEN_LO. On the next edge: cpu_resetq=0, err=0, word index cleared.
  - boot_req in any loading state is ignored.
- A synchronous reset at any point, including mid-load, returns all outputs to their reset values. A partially written image is not erased.
- Simultaneous events:
  - A byte accept and a timeout expiry in the same cycle: the accept wins.
  - boot_req together with rx_valid in RUN: re-arm only; no byte is consumed (rx_ready is 0 that cycle).

Optional Feature:
- Macro J1_BOOT_CHECKSUM_EN.
- Defined:
  - A CHECK state follows the last data word and expects one extra byte.
  - That byte must equal the 8-bit modulo-256 sum of all LEN and data bytes.
  - Match -> RUN; mismatch -> ERROR. The timeout applies in CHECK.
- Undefined: no CHECK state and no checksum accumulator; the last word goes straight to RUN.

Decomposition:
- Shared package j1_pkg holds:
  - the state enumeration (LEN_LO, LEN_HI, DAT_LO, DAT_HI, CHECK, RUN, ERROR);
  - localparam J1_CODE_AW=13, also used by the code RAM and CPU code_addr.
- One natural sub-module, j1_boot_timeout: a loadable idle counter with inputs clear and enable, and output expired.
- Everything else stays in j1_boot_ctrl.

Test Plan:
- Load 2 words (feature off): bytes 02 00 34 12 CD AB -> code_we pulses twice with (0,0x1234) then (1,0xABCD); cpu_resetq rises no earlier than the second pulse edge; busy=0; err=0.
- Feature on: bytes 01 00 01 80, then checksum 0x82 -> RUN. Repeat with checksum 0x83 -> ERROR, err=1, cpu_resetq held 0, no further rx accepts.
- Oversize header: bytes 01 20 (N=0x2001, CODE_AW=13) -> ERROR after LEN_HI; no code_we ever asserted.
- Timeout (TIMEOUT_CYC=16): bytes 01 00 then 15 idle clocks -> still DAT_LO; 16 idle clocks -> ERROR. A byte arriving on the expiry cycle keeps the load alive.
- Re-arm: while in RUN, pulse boot_req -> cpu_resetq=0 next cycle, rx_ready=1. Load bytes 01 00 EF BE -> code_we (0,0xBEEF), then RUN.
- Reset mid-load: assert reset while in DAT_HI -> next cycle state=LEN_LO, cpu_resetq=0, code_we=0, err=0. A fresh image of 0 words (bytes 00 00) goes straight to RUN with feature off.
